// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store memory master.
//   size_t      - access size (byte, half, word)
//   state_t     - control FSM states
//   WORD_BYTES  - bytes per memory word
//   LANE_BITS   - byte-address bits that select a lane inside a word
//   decode_size - maps the 2-bit core size code to size_t (11 -> word)
package lsu_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LANE_BITS  = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MERGE_WR,
        WR,
        RESP
    } state_t;

    function automatic size_t decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane handling for the load/store master.
// Little-endian lanes: byte lane n is bits [8n+7:8n]; a half uses lane 0
// or lane 2 (selected by lane[1] alone, so lane[0] is ignored for halves);
// a word ignores the lane entirely.
// Ports:
//   size        in  access size
//   lane        in  byte address bits [1:0]
//   is_unsigned in  zero-extend instead of sign-extend on loads
//   rdata       in  word read from memory
//   wdata       in  right-aligned store data
//   load_data   out extracted and extended load result
//   merged      out rdata with the target lane replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val  = rdata[{lane, 3'b000} +: 8];
        half_val  = lane[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        merged    = wdata;
        case (size)
            SZ_B: begin
                load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
                merged    = rdata;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
                merged    = rdata;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator in front of a 1-based, word-indexed
// memory with a one-cycle synchronous read and no byte enables. Sub-word
// stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// halves/words complete with resp_err and no memory access; otherwise the
// low address bits are ignored (aligned down).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   core_valid/core_ready      request handshake (accept = valid && ready)
//   core_addr/we/size/unsigned/wdata  access description
//   resp_valid/rdata/err       single-cycle completion, no backpressure
//   mem_request/write/address/write_data  memory command (address = index+1)
//   mem_sync_read_data         read data, valid the cycle after a read
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic [1:0]        core_size,
    input  logic              core_unsigned,
    input  logic [31:0]       core_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_request,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_sync_read_data
);

    // Handshake: the core presents an access with core_valid and must hold
    // it until core_ready (high only in IDLE) is seen together with it;
    // that cycle is the accept cycle. Completion is a one-cycle resp_valid.

    state_t state, state_n;

    // Access fields captured on accept.
    size_t       size_q;
    logic [1:0]  lane_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    // Registered-output next values.
    logic              req_n, write_n, rvalid_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n, rdata_n;

    size_t             acc_size;
    logic [ADDR_W-1:0] word_off;
    logic              out_of_range;
    logic              reject;
    logic [31:0]       load_data, merged;

    assign acc_size     = decode_size(core_size);
    assign word_off     = core_addr >> LANE_BITS;
    assign out_of_range = word_off >= ADDR_W'(MEM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((acc_size == SZ_H) && core_addr[0]) ||
                        ((acc_size == SZ_W) && (core_addr[1:0] != 2'b00));
    assign reject     = out_of_range || misaligned;
`else
    assign reject     = out_of_range;
`endif

    assign core_ready = (state == IDLE);

    lsu_lane_align u_align (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .rdata       (mem_sync_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Outputs are computed alongside the next state and registered, so each
    // output reflects the state being entered.
    always_comb begin
        state_n  = state;
        req_n    = 1'b0;
        write_n  = 1'b0;
        rvalid_n = 1'b0;
        err_n    = 1'b0;
        rdata_n  = 32'd0;
        addr_n   = mem_address;
        wdata_n  = mem_write_data;
        case (state)
            IDLE: begin
                if (core_valid) begin
                    if (reject) begin
                        state_n  = RESP;
                        rvalid_n = 1'b1;
                        err_n    = 1'b1;
                    end else begin
                        req_n  = 1'b1;
                        addr_n = word_off + ADDR_W'(1);
                        if (core_we && (acc_size == SZ_W)) begin
                            state_n = WR;
                            write_n = 1'b1;
                            wdata_n = core_wdata;
                        end else begin
                            // loads and sub-word stores both start with a read
                            state_n = RD_REQ;
                        end
                    end
                end
            end
            RD_REQ: state_n = RD_WAIT;
            RD_WAIT: begin
                if (we_q) begin
                    state_n = MERGE_WR;
                    req_n   = 1'b1;
                    write_n = 1'b1;
                    wdata_n = merged;
                end else begin
                    state_n  = RESP;
                    rvalid_n = 1'b1;
                    rdata_n  = load_data;
                end
            end
            MERGE_WR, WR: begin
                state_n  = RESP;
                rvalid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mem_request    <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 32'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            size_q         <= SZ_B;
            lane_q         <= 2'd0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            wdata_q        <= 32'd0;
        end else begin
            state          <= state_n;
            mem_request    <= req_n;
            mem_write      <= write_n;
            mem_address    <= addr_n;
            mem_write_data <= wdata_n;
            resp_valid     <= rvalid_n;
            resp_rdata     <= rdata_n;
            resp_err       <= err_n;
            if (state == IDLE && core_valid) begin
                size_q  <= acc_size;
                lane_q  <= core_addr[1:0];
                we_q    <= core_we;
                uns_q   <= core_unsigned;
                wdata_q <= core_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed accesses against a 256-word 1-based
// memory model, checking latency, memory traffic and response values.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_valid = 1'b0;
    logic        core_ready;
    logic [31:0] core_addr = 32'd0;
    logic        core_we = 1'b0;
    logic [1:0]  core_size = 2'd0;
    logic        core_unsigned = 1'b0;
    logic [31:0] core_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_sync_read_data = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk                (clk),
        .rst                (rst),
        .core_valid         (core_valid),
        .core_ready         (core_ready),
        .core_addr          (core_addr),
        .core_we            (core_we),
        .core_size          (core_size),
        .core_unsigned      (core_unsigned),
        .core_wdata         (core_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .resp_err           (resp_err),
        .mem_request        (mem_request),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_write_data     (mem_write_data),
        .mem_sync_read_data (mem_sync_read_data)
    );

    // memory model: 1-based word index, one-cycle synchronous read
    logic [31:0] mem [0:255];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (mem_request) begin
            if (mem_address >= 32'd1 && mem_address <= 32'd256) begin
                if (mem_write) begin
                    mem[mem_address - 32'd1] <= mem_write_data;
                    wr_cnt++;
                    last_wa <= mem_address;
                    last_wd <= mem_write_data;
                end else begin
                    mem_sync_read_data <= mem[mem_address - 32'd1];
                    rd_cnt++;
                end
            end else begin
                $display("FAIL mem_range address=%0d outside 1..256", mem_address);
                n_cmp++;
                n_bad++;
            end
        end
    end

    // One access; lat = cycles from the accept cycle to resp_valid (-1 on timeout).
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int dr, output int dw);
        int r0, w0;
        @(negedge clk);
        core_valid = 1'b1; core_addr = addr; core_we = we;
        core_size = size; core_unsigned = uns; core_wdata = wdata;
        r0 = rd_cnt; w0 = wr_cnt;
        lat = -1; rdata = 32'hxxxxxxxx; err = 1'bx;
        n_cmp++; if (core_ready !== 1'b1) begin n_bad++; $display("FAIL ready_idle got %b want 1", core_ready); end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            core_valid = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        dr = rd_cnt - r0;
        dw = wr_cnt - w0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, dr, dw;

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (core_ready !== 1'b1)      begin n_bad++; $display("FAIL rst_ready got %b want 1", core_ready); end
        n_cmp++; if (resp_valid !== 1'b0)      begin n_bad++; $display("FAIL rst_rvalid got %b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0)        begin n_bad++; $display("FAIL rst_err got %b want 0", resp_err); end
        n_cmp++; if (mem_request !== 1'b0)     begin n_bad++; $display("FAIL rst_req got %b want 0", mem_request); end
        n_cmp++; if (mem_write !== 1'b0)       begin n_bad++; $display("FAIL rst_write got %b want 0", mem_write); end
        n_cmp++; if (resp_rdata !== 32'd0)     begin n_bad++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        n_cmp++; if (mem_address !== 32'd0)    begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_address); end
        n_cmp++; if (mem_write_data !== 32'd0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", mem_write_data); end
        rst = 1'b0;
    endtask

    task automatic test_word_store_load;
        do_access(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat, dr, dw);
        n_cmp++; if (lat !== 2)              begin n_bad++; $display("FAIL wst_lat got %0d want 2", lat); end
        n_cmp++; if (er !== 1'b0)            begin n_bad++; $display("FAIL wst_err got %b want 0", er); end
        n_cmp++; if (rd !== 32'd0)           begin n_bad++; $display("FAIL wst_rdata got %h want 0", rd); end
        n_cmp++; if (dw !== 1 || dr !== 0)   begin n_bad++; $display("FAIL wst_traffic got rd=%0d wr=%0d want 0/1", dr, dw); end
        n_cmp++; if (last_wa !== 32'd5)      begin n_bad++; $display("FAIL wst_addr got %0d want 5", last_wa); end
        n_cmp++; if (last_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wst_data got %h want deadbeef", last_wd); end
        do_access(32'h10, 1'b0, 2'b10, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (lat !== 3)              begin n_bad++; $display("FAIL wld_lat got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF)    begin n_bad++; $display("FAIL wld_rdata got %h want deadbeef", rd); end
        n_cmp++; if (dr !== 1 || dw !== 0)   begin n_bad++; $display("FAIL wld_traffic got rd=%0d wr=%0d want 1/0", dr, dw); end
        // size code 11 behaves as a word
        do_access(32'h10, 1'b0, 2'b11, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'hDEADBEEF)    begin n_bad++; $display("FAIL sz11_rdata got %h want deadbeef", rd); end
    endtask

    task automatic test_subword_merge;
        do_access(32'h20, 1'b1, 2'b10, 1'b0, 32'h11223344, rd, er, lat, dr, dw);
        do_access(32'h22, 1'b1, 2'b00, 1'b0, 32'h000000AB, rd, er, lat, dr, dw);
        n_cmp++; if (lat !== 4)              begin n_bad++; $display("FAIL bst_lat got %0d want 4", lat); end
        n_cmp++; if (dr !== 1 || dw !== 1)   begin n_bad++; $display("FAIL bst_traffic got rd=%0d wr=%0d want 1/1", dr, dw); end
        n_cmp++; if (last_wa !== 32'd9)      begin n_bad++; $display("FAIL bst_addr got %0d want 9", last_wa); end
        n_cmp++; if (last_wd !== 32'h11AB3344) begin n_bad++; $display("FAIL bst_data got %h want 11ab3344", last_wd); end
        do_access(32'h22, 1'b0, 2'b00, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'hFFFFFFAB)    begin n_bad++; $display("FAIL bld_s got %h want ffffffab", rd); end
        do_access(32'h22, 1'b0, 2'b00, 1'b1, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'h000000AB)    begin n_bad++; $display("FAIL bld_u got %h want 000000ab", rd); end
        do_access(32'h23, 1'b0, 2'b00, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'h00000011)    begin n_bad++; $display("FAIL bld_l3 got %h want 00000011", rd); end
    endtask

    task automatic test_half;
        do_access(32'h30, 1'b1, 2'b10, 1'b0, 32'h80017FFE, rd, er, lat, dr, dw);
        do_access(32'h32, 1'b0, 2'b01, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'hFFFF8001)    begin n_bad++; $display("FAIL hld_hi got %h want ffff8001", rd); end
        do_access(32'h30, 1'b0, 2'b01, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'h00007FFE)    begin n_bad++; $display("FAIL hld_lo got %h want 00007ffe", rd); end
        do_access(32'h32, 1'b0, 2'b01, 1'b1, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'h00008001)    begin n_bad++; $display("FAIL hld_u got %h want 00008001", rd); end
        do_access(32'h32, 1'b1, 2'b01, 1'b0, 32'hFFFF1234, rd, er, lat, dr, dw);
        n_cmp++; if (last_wd !== 32'h12347FFE) begin n_bad++; $display("FAIL hst_data got %h want 12347ffe", last_wd); end
    endtask

    task automatic test_out_of_range;
        do_access(32'h400, 1'b0, 2'b10, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (er !== 1'b1)            begin n_bad++; $display("FAIL oor_err got %b want 1", er); end
        n_cmp++; if (lat !== 1)              begin n_bad++; $display("FAIL oor_lat got %0d want 1", lat); end
        n_cmp++; if (dr !== 0 || dw !== 0)   begin n_bad++; $display("FAIL oor_traffic got rd=%0d wr=%0d want 0/0", dr, dw); end
        n_cmp++; if (rd !== 32'd0)           begin n_bad++; $display("FAIL oor_rdata got %h want 0", rd); end
        do_access(32'h10, 1'b0, 2'b10, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL oor_next got err=%b data=%h want 0/deadbeef", er, rd); end
        // last in-range word (index 255, mem_address 256)
        do_access(32'h3FC, 1'b1, 2'b10, 1'b0, 32'h0BADF00D, rd, er, lat, dr, dw);
        n_cmp++; if (er !== 1'b0 || last_wa !== 32'd256) begin n_bad++; $display("FAIL top_word got err=%b addr=%0d want 0/256", er, last_wa); end
        do_access(32'h3FF, 1'b0, 2'b00, 1'b1, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0000000B) begin n_bad++; $display("FAIL top_byte got err=%b data=%h want 0/0000000b", er, rd); end
    endtask

    task automatic test_reset_mid_rmw;
        int w0;
        logic rv_seen;
        do_access(32'h50, 1'b1, 2'b10, 1'b0, 32'h55667788, rd, er, lat, dr, dw);
        w0 = wr_cnt;
        rv_seen = 1'b0;
        @(negedge clk);
        core_valid = 1'b1; core_addr = 32'h51; core_we = 1'b1;
        core_size = 2'b00; core_unsigned = 1'b0; core_wdata = 32'h99;
        @(negedge clk);                     // RD_REQ
        core_valid = 1'b0;
        n_cmp++; if (mem_request !== 1'b1 || mem_write !== 1'b0) begin n_bad++; $display("FAIL rmw_rdreq got req=%b we=%b want 1/0", mem_request, mem_write); end
        @(negedge clk);                     // RD_WAIT
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_request !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL rmw_drop got req=%b we=%b want 0/0", mem_request, mem_write); end
        if (resp_valid === 1'b1) rv_seen = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (core_ready !== 1'b1)    begin n_bad++; $display("FAIL rmw_ready got %b want 1", core_ready); end
        if (resp_valid === 1'b1) rv_seen = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid === 1'b1) rv_seen = 1'b1;
        end
        n_cmp++; if (rv_seen !== 1'b0)       begin n_bad++; $display("FAIL rmw_noresp got %b want 0", rv_seen); end
        n_cmp++; if (wr_cnt !== w0)          begin n_bad++; $display("FAIL rmw_nowrite got %0d writes want 0", wr_cnt - w0); end
        n_cmp++; if (mem[20] !== 32'h55667788) begin n_bad++; $display("FAIL rmw_mem got %h want 55667788", mem[20]); end
        do_access(32'h50, 1'b0, 2'b10, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (rd !== 32'h55667788 || lat !== 3) begin n_bad++; $display("FAIL rmw_after got %h lat %0d want 55667788 lat 3", rd, lat); end
    endtask

    task automatic test_misalign;
        do_access(32'h40, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, lat, dr, dw);
        do_access(32'h41, 1'b0, 2'b10, 1'b0, 32'd0, rd, er, lat, dr, dw);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++; if (er !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL mis_word got err=%b lat=%0d want 1/1", er, lat); end
        n_cmp++; if (dr !== 0 || dw !== 0)     begin n_bad++; $display("FAIL mis_traffic got rd=%0d wr=%0d want 0/0", dr, dw); end
`else
        n_cmp++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mis_word got err=%b data=%h want 0/cafef00d", er, rd); end
        n_cmp++; if (dr !== 1 || lat !== 3)    begin n_bad++; $display("FAIL mis_traffic got rd=%0d lat=%0d want 1/3", dr, lat); end
`endif
        do_access(32'h43, 1'b0, 2'b01, 1'b0, 32'd0, rd, er, lat, dr, dw);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_bad++; $display("FAIL mis_half got err=%b data=%h want 1/0", er, rd); end
`else
        n_cmp++; if (er !== 1'b0 || rd !== 32'hFFFFCAFE) begin n_bad++; $display("FAIL mis_half got err=%b data=%h want 0/ffffcafe", er, rd); end
`endif
        do_access(32'h41, 1'b0, 2'b00, 1'b0, 32'd0, rd, er, lat, dr, dw);
        n_cmp++; if (er !== 1'b0 || rd !== 32'hFFFFFFF0) begin n_bad++; $display("FAIL byte_odd got err=%b data=%h want 0/fffffff0", er, rd); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_merge();
        test_half();
        test_out_of_range();
        test_reset_mid_rmw();
        test_misalign();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the main memory port (request, write, address, write data, synchronous read data) on behalf of the core.
- Accepts one byte, half or word access at a time over a valid/ready handshake and converts the byte address to the memory's word index.
- Performs read-modify-write for sub-word stores, because the memory has no byte enables.
- Extracts and sign/zero-extends load data, then returns a single-cycle response to the core.

Parameters:
- MEM_WORDS, 256, memory depth in words; word indices at or above MEM_WORDS are out of range.
- ADDR_W, 32, width of the core byte address and the memory address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- core_valid  in  1  access request from the core.
- core_ready  out  1  high only in IDLE; the access is accepted when core_valid && core_ready.
- core_addr  in  32  byte address.
- core_we  in  1  1 = store, 0 = load.
- core_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- core_unsigned  in  1  zero-extend the load instead of sign-extending it.
- core_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; there is no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  error flag, valid with resp_valid.
- mem_request  out  1  memory request.
- mem_write  out  1  memory write enable.
- mem_address  out  32  word index + 1 (the memory is 1-based word indexed).
- mem_write_data  out  32  full word to write.
- mem_sync_read_data  in  32  read data, valid the cycle after a read request.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; core_ready = 1; resp_valid, resp_err, mem_request and mem_write = 0; resp_rdata, mem_address and mem_write_data = 0.
- All outputs except core_ready are registered.
- Accept: in IDLE, when core_valid = 1, latch addr, we, size, unsigned and wdata. Compute word index = (core_addr >> 2) + 1 and lane = core_addr[1:0].
- FSM states: IDLE, RD_REQ, RD_WAIT, MERGE_WR, WR, RESP.
- Load: IDLE -> RD_REQ (mem_request = 1, mem_write = 0) -> RD_WAIT (capture mem_sync_read_data, extract) -> RESP (resp_valid = 1) -> IDLE.
  - resp_valid rises 3 cycles after the accept cycle.
- Word store: IDLE -> WR (mem_request = 1, mem_write = 1, mem_write_data = wdata) -> RESP -> IDLE.
  - resp_valid rises 2 cycles after accept.
- Sub-word store: IDLE -> RD_REQ -> RD_WAIT (merge wdata lane into the read word) -> MERGE_WR (write the merged word) -> RESP -> IDLE.
  - resp_valid rises 4 cycles after accept.
- mem_request is high for exactly one cycle per memory access and is never high in IDLE or RESP.
- Lane rules (little-endian):
  - Byte lane n occupies bits [8n+7:8n].
  - Half uses lane 0 (bits [15:0]) or lane 2 (bits [31:16]).
  - Loads sign-extend from bit 7 or bit 15 unless unsigned.
  - A merge replaces only the target lane; the other bits come from the read word.
- Out-of-range: word index - 1 >= MEM_WORDS gives resp_err = 1 with no memory access; the FSM goes IDLE -> RESP directly.
- core_ready is low in every non-IDLE state; core_valid is ignored there and the core must hold its request.
- Reset mid-operation returns to IDLE and drops mem_request and mem_write on the next edge.
  - A write not yet issued is discarded.
  - No response is produced for the aborted access.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: a misaligned access gets resp_err = 1 with no memory access, taking the IDLE -> RESP path. Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
- Not defined: misaligned addresses are aligned down (half ignores addr[0], word ignores addr[1:0]) and resp_err reflects only the out-of-range condition.

Decomposition:
- Package lsu_pkg:
  - size_t enum (SZ_B, SZ_H, SZ_W);
  - state_t enum for the six states;
  - WORD_BYTES = 4.
- Sub-module lsu_lane_align: purely combinational; performs lane extraction with extension and the store merge. Instantiated once in lsu_mem_master.

Test Plan:
- Word store then load: store 0xDEADBEEF at addr 0x10 -> mem_address = 5 on a single write cycle, resp after 2 cycles; load of 0x10 -> resp_rdata = 0xDEADBEEF after 3 cycles.
- Sub-word store merge: word at 0x20 = 0x11223344; store byte 0xAB at 0x22 -> read then write of 0x11AB3344; signed byte load at 0x22 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half load: word 0x8001_7FFE at 0x30; signed half at 0x32 -> 0xFFFF8001; at 0x30 -> 0x00007FFE.
- Out of range: load at 0x400 (word index 257 > MEM_WORDS) -> resp_err = 1 with no mem_request pulse; next access proceeds normally.
- Reset mid-RMW: assert rst in RD_WAIT of a byte store -> no mem_write; memory word unchanged; core_ready = 1 the cycle after reset releases.
- Misaligned word at 0x41: with LSU_MISALIGN_TRAP_EN -> resp_err = 1 and no access; without it -> the word at 0x40 is accessed with resp_err = 0.
